fifo_sync_param: RTL and testbench



---
 rtl/fifo_sync_param.sv | 117 +++++++++++
 tb/tb_fifo_sync_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with thresholds, occupancy and sticky errors.
// Optional FIFO_WATERMARK_EN adds a max_count high-water-mark output.
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
`ifdef FIFO_WATERMARK_EN
  ,
  output logic [$clog2(DEPTH):0]   max_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_nxt;
  logic             wr_acc;
  logic             rd_acc;

  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  assign full         = (count == FULL_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Occupancy after this edge; a simultaneous read and write cancel out.
  always_comb begin
    cnt_nxt = count;
    if (clear) begin
      cnt_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      cnt_nxt = count + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      cnt_nxt = count - 1'b1;
    end
  end

  // Storage array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc && !clear) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, read data and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= cnt_nxt;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_en && !rd_acc) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_WATERMARK_EN
  // High-water mark of occupancy since the last reset or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_count <= '0;
    end else if (clear) begin
      max_count <= '0;
    end else if (cnt_nxt > max_count) begin
      max_count <= cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: vector table, directed corners, random vs queue model.
// Checks max_count too when FIFO_WATERMARK_EN is defined.
module tb_fifo_sync_param;

  localparam int D  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [7:0]    data_in = '0;
  logic [7:0]    data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;
`ifdef FIFO_WATERMARK_EN
  logic [CW-1:0] max_count;
`endif

  fifo_sync_param #(
    .WIDTH(8), .DEPTH(D), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .wr_en(wr_en),
    .data_in(data_in),
    .rd_en(rd_en),
    .data_out(data_out),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
`ifdef FIFO_WATERMARK_EN
    ,
    .max_count(max_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       clr;
    bit       wr;
    bit       rd;
    bit [7:0] d;
    int       cnt;
    bit [7:0] dout;
    bit       ful;
    bit       emp;
    bit       ovf;
    bit       unf;
  } vec_t;

  vec_t tbl[35];

  byte unsigned q[$];
  logic [7:0]   m_dout;
  bit           m_ovf;
  bit           m_unf;
  int           m_max;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_max  = 0;
  endtask

  task automatic model_step(input bit c, input bit w,
                            input bit r, input logic [7:0] d);
    bit rok;
    bit wok;
    if (c) begin
      model_reset();
    end else begin
      rok = r && (q.size() > 0);
      wok = w && ((q.size() < D) || rok);
      if (r && !rok) m_unf = 1'b1;
      if (w && !wok) m_ovf = 1'b1;
      if (rok) m_dout = q.pop_front();
      if (wok) q.push_back(d);
      if (q.size() > m_max) m_max = q.size();
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("count", 32'(count), n);
    chk("full", 32'(full), 32'(n == D));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_WATERMARK_EN
    chk("max_count", 32'(max_count), m_max);
`endif
  endtask

  task automatic step(input bit c, input bit w,
                      input bit r, input logic [7:0] d);
    @(negedge clk);
    clear   = c;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
    model_step(c, w, r, d);
    check_model();
    clear = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{0, 1, 0, 8'(i + 1), i + 1, 8'h00,
                 (i == 15), 0, 0, 0};
    end
    tbl[16] = '{0, 1, 0, 8'hAA, 16, 8'h00, 1, 0, 1, 0};
    for (int k = 0; k < 16; k++) begin
      tbl[17 + k] = '{0, 0, 1, 8'h00, 15 - k, 8'(k + 1),
                      0, (k == 15), 1, 0};
    end
    tbl[33] = '{0, 1, 1, 8'h55, 1, 8'h10, 0, 0, 1, 1};
    tbl[34] = '{0, 0, 1, 8'h00, 0, 8'h55, 0, 1, 1, 1};

    // asynchronous reset state before any clock edge
    model_reset();
    #2;
    check_model();
    @(negedge clk);
    rst = 1'b1;

    // vector table: fill, overflow, drain, empty read+write
    for (int i = 0; i < 35; i++) begin
      step(tbl[i].clr, tbl[i].wr, tbl[i].rd, tbl[i].d);
      chk("tbl_count", 32'(count), tbl[i].cnt);
      chk("tbl_dout", 32'(data_out), 32'(tbl[i].dout));
      chk("tbl_full", 32'(full), 32'(tbl[i].ful));
      chk("tbl_empty", 32'(empty), 32'(tbl[i].emp));
      chk("tbl_ovf", 32'(overflow), 32'(tbl[i].ovf));
      chk("tbl_unf", 32'(underflow), 32'(tbl[i].unf));
    end

    // full FIFO with simultaneous read and write
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'h21 + i));
    step(0, 1, 1, 8'h77);
    chk("full_rw_count", 32'(count), 16);
    chk("full_rw_dout", 32'(data_out), 32'h21);
    chk("full_rw_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 8'h00);
    chk("last_word", 32'(data_out), 32'h77);
    chk("drained", 32'(empty), 1);

    // 20 writes interleaved with 15 reads, pointers wrap
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 8'(8'h80 + i));
      if (i % 4 != 0) step(0, 0, 1, 8'h00);
    end
    chk("wrap_count", 32'(count), 5);

    // synchronous flush
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'hC0 + i));
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'hC9);
    step(1, 1, 1, 8'hEE);
    chk("clear_count", 32'(count), 0);
    chk("clear_empty", 32'(empty), 1);
    chk("clear_dout", 32'(data_out), 0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 17; i++) step(0, 1, 0, 8'(8'h40 + i));
    step(0, 0, 1, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    rst = 1'b1;
    step(0, 1, 0, 8'h9C);
    step(0, 0, 1, 8'h00);
    chk("post_rst_read", 32'(data_out), 32'h9C);

    // randomized traffic against the queue model
    for (int i = 0; i < 2000; i++) begin
      bit c;
      bit w;
      bit r;
      int bias;
      bias = ((i / 150) % 2 == 0) ? 70 : 30;
      c = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 99) < bias);
      r = ($urandom_range(0, 99) < 100 - bias);
      step(c, w, r, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
